strip_header: RTL
=================

Name: strip_header

Overview:
- Receive-side counterpart of the capture header inserter.
- Consumes a 512-bit stream in which each packet is preceded by one header beat, strips the header, and republishes the header fields as registered sidebands.
- Regenerates TKEEP on the final data beat from the header byte count.
- Recognises the hard-stop filler beats that end a capture and reports capture completion.
- Sits between the RAM-readback path and host-side packet consumers.

Parameters:
- DW, 512, stream data width in bits; fixed to 512 because the header layout depends on it.
- MAGIC, 56'h666c6f57202e44, expected header signature in bits [55:0].

Ports:
- sys_clk  in  1  the single clock.
- sys_reset  in  1  synchronous, active-high reset.
- AXIS_IN_TDATA  in  DW  headered input stream.
- AXIS_IN_TLAST  in  1  last beat of the packet body.
- AXIS_IN_TVALID  in  1
- AXIS_IN_TREADY  out  1
- AXIS_OUT_TDATA  out  DW  packet body.
- AXIS_OUT_TKEEP  out  DW/8  byte enables regenerated from the header length.
- AXIS_OUT_TLAST  out  1
- AXIS_OUT_TVALID  out  1
- AXIS_OUT_TREADY  in  1
- pkt_length  out  16  bytes in the current packet.
- pkt_timestamp  out  64  capture timestamp of the current packet.
- pkt_channel  out  8  source channel of the current packet.
- hdr_strobe  out  1  one-cycle pulse when a valid header is accepted.
- capture_done  out  1  sticky flag; set on the first filler beat.
- packet_count  out  32  valid headers accepted.
- bad_header_count  out  16  saturating count of headers rejected for bad magic or zero length.
- length_error_count  out  16  saturating count of packets whose TLAST disagreed with the header length.

Behaviour:
- Interface: one clock, sys_clk; sys_reset is synchronous and active-high.
- Reset: all outputs, sidebands and counters go to 0; FSM goes to S_HDR. Reset mid-packet abandons the packet; no TLAST is emitted for it.
- Header layout in the input beat: [143:128] length, [127:64] timestamp, [63:56] channel, [55:0] magic. Bits [511:144] are ignored.
- Filler beat: every byte equals 8'hFC.
- FSM state S_HDR:
  - AXIS_IN_TREADY=1; AXIS_OUT_TVALID=0.
  - On input handshake, filler beat: go to S_STOP and set capture_done.
  - On input handshake, magic mismatch or length==0: drop the beat, increment bad_header_count, stay in S_HDR (resynchronise on the next beat).
  - Otherwise:
    - Latch pkt_length, pkt_timestamp and pkt_channel.
    - Load remaining = length.
    - Pulse hdr_strobe; increment packet_count.
    - Go to S_DATA.
- FSM state S_DATA (zero latency, combinational pass-through):
  - AXIS_OUT_TDATA=AXIS_IN_TDATA.
  - AXIS_OUT_TVALID=AXIS_IN_TVALID.
  - AXIS_IN_TREADY=AXIS_OUT_TREADY.
  - AXIS_OUT_TLAST=AXIS_IN_TLAST.
  - AXIS_OUT_TKEEP: all ones if remaining>=64, else (1<<remaining)-1; remaining==0 gives 0.
  - Per handshake: remaining <= (remaining>=64) ? remaining-64 : 0.
  - On TLAST handshake: if remaining>64 (early TLAST) or remaining was 0 entering the beat (late TLAST), increment length_error_count. Return to S_HDR.
- FSM state S_STOP:
  - AXIS_IN_TREADY=1; all input is consumed and discarded; AXIS_OUT_TVALID=0.
  - Stay in S_STOP until reset.
- Sidebands stay stable from hdr_strobe until the next accepted header.
- Counters saturate at all-ones; packet_count wraps.
- Arithmetic: remaining is 16 bits unsigned, decremented by 64 per beat and clamped at 0.
- Output AXIS rules: TVALID must not depend on TREADY; data must be held while TVALID&~TREADY (inherent in the pass-through).

Optional Feature:
- Macro: CHANNEL_FILTER_EN.
- When defined:
  - Adds parameter CHANNEL (default 0).
  - Packets whose header channel != CHANNEL are accepted and their body is consumed with AXIS_IN_TREADY=1 and AXIS_OUT_TVALID=0 until the input TLAST.
  - hdr_strobe is suppressed and packet_count is not incremented for those packets.
  - Adds output filtered_count (32 bits, wraps).
- When undefined: all valid packets pass, and there is no CHANNEL parameter and no filtered_count port.

Test Plan:
- Header (len=100, ts=64'h1234, ch=1, good magic) plus 2 body beats with TLAST on beat 2 -> 2 output beats; TKEEP all ones then 64'h0000000FFFFFFFFF; pkt_length=100; hdr_strobe pulses once; packet_count=1.
- Header len=64 plus 1 beat, with AXIS_OUT_TREADY toggling 0/1 every cycle -> single beat, TKEEP all ones, TLAST=1; no data loss or duplication.
- Bad-magic beat followed by a good header with len=1 -> bad_header_count=1; output is one beat with TKEEP=64'h1.
- Header len=200 with TLAST on beat 2 -> length_error_count=1; FSM returns to S_HDR and the next packet decodes correctly.
- One filler beat (all 8'hFC) followed by 63 filler beats and then a valid header -> capture_done=1; no output; TREADY stays 1; the header is ignored.
- Reset asserted during beat 1 of a 3-beat packet -> next cycle all counters 0, AXIS_OUT_TVALID=0; the next header decodes normally.

Source files
------------

// File: rtl/strip_header.sv
// Strips the per-packet header beat from a 512-bit capture stream, republishes header fields as sidebands.
// Optional macro CHANNEL_FILTER_EN: drop bodies whose header channel differs from parameter CHANNEL.
module strip_header #(
    parameter int          DW    = 512,
    parameter logic [55:0] MAGIC = 56'h666c6f57202e44
`ifdef CHANNEL_FILTER_EN
    ,
    parameter logic [7:0]  CHANNEL = 8'd0
`endif
) (
    input  logic            sys_clk,
    input  logic            sys_reset,
    input  logic [DW-1:0]   AXIS_IN_TDATA,
    input  logic            AXIS_IN_TLAST,
    input  logic            AXIS_IN_TVALID,
    output logic            AXIS_IN_TREADY,
    output logic [DW-1:0]   AXIS_OUT_TDATA,
    output logic [DW/8-1:0] AXIS_OUT_TKEEP,
    output logic            AXIS_OUT_TLAST,
    output logic            AXIS_OUT_TVALID,
    input  logic            AXIS_OUT_TREADY,
    output logic [15:0]     pkt_length,
    output logic [63:0]     pkt_timestamp,
    output logic [7:0]      pkt_channel,
    output logic            hdr_strobe,
    output logic            capture_done,
    output logic [31:0]     packet_count,
    output logic [15:0]     bad_header_count,
    output logic [15:0]     length_error_count
`ifdef CHANNEL_FILTER_EN
    ,
    output logic [31:0]     filtered_count
`endif
);

    typedef enum logic [1:0] {S_HDR, S_DATA, S_STOP, S_SKIP} state_t;

    state_t        state;
    logic [15:0]   remaining;

    logic [15:0]   hdr_len;
    logic [63:0]   hdr_ts;
    logic [7:0]    hdr_ch;
    logic [55:0]   hdr_magic;
    logic          is_filler;
    logic          channel_ok;
    logic          in_hs;
    logic          rem_ge64;
    logic [DW/8-1:0] keep_tail;

    assign hdr_len   = AXIS_IN_TDATA[143:128];
    assign hdr_ts    = AXIS_IN_TDATA[127:64];
    assign hdr_ch    = AXIS_IN_TDATA[63:56];
    assign hdr_magic = AXIS_IN_TDATA[55:0];
    assign is_filler = (AXIS_IN_TDATA == {(DW/8){8'hFC}});

`ifdef CHANNEL_FILTER_EN
    assign channel_ok = (hdr_ch == CHANNEL);
`else
    assign channel_ok = 1'b1;
`endif

    assign rem_ge64  = (remaining >= 16'd64);
    // Below one full beat, remaining is < 64 so a 6-bit shift covers every tail length.
    assign keep_tail = ({{(DW/8-1){1'b0}}, 1'b1} << remaining[5:0]) - {{(DW/8-1){1'b0}}, 1'b1};

    always_comb begin
        AXIS_IN_TREADY  = 1'b1;
        AXIS_OUT_TVALID = 1'b0;
        AXIS_OUT_TDATA  = '0;
        AXIS_OUT_TLAST  = 1'b0;
        AXIS_OUT_TKEEP  = '0;
        if (state == S_DATA) begin
            AXIS_IN_TREADY  = AXIS_OUT_TREADY;
            AXIS_OUT_TVALID = AXIS_IN_TVALID;
            AXIS_OUT_TDATA  = AXIS_IN_TDATA;
            AXIS_OUT_TLAST  = AXIS_IN_TLAST;
            AXIS_OUT_TKEEP  = rem_ge64 ? '1 : keep_tail;
        end
    end

    assign in_hs = AXIS_IN_TVALID & AXIS_IN_TREADY;

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state              <= S_HDR;
            remaining          <= '0;
            pkt_length         <= '0;
            pkt_timestamp      <= '0;
            pkt_channel        <= '0;
            hdr_strobe         <= 1'b0;
            capture_done       <= 1'b0;
            packet_count       <= '0;
            bad_header_count   <= '0;
            length_error_count <= '0;
`ifdef CHANNEL_FILTER_EN
            filtered_count     <= '0;
`endif
        end else begin
            hdr_strobe <= 1'b0;
            case (state)
                S_HDR: begin
                    if (in_hs) begin
                        if (is_filler) begin
                            state        <= S_STOP;
                            capture_done <= 1'b1;
                        end else if (hdr_magic != MAGIC || hdr_len == 16'd0) begin
                            if (bad_header_count != 16'hFFFF)
                                bad_header_count <= bad_header_count + 16'd1;
                        end else if (!channel_ok) begin
`ifdef CHANNEL_FILTER_EN
                            filtered_count <= filtered_count + 32'd1;
                            state          <= S_SKIP;
`endif
                        end else begin
                            pkt_length    <= hdr_len;
                            pkt_timestamp <= hdr_ts;
                            pkt_channel   <= hdr_ch;
                            remaining     <= hdr_len;
                            hdr_strobe    <= 1'b1;
                            packet_count  <= packet_count + 32'd1;
                            state         <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (in_hs) begin
                        remaining <= rem_ge64 ? remaining - 16'd64 : 16'd0;
                        if (AXIS_IN_TLAST) begin
                            // Early TLAST leaves more than a beat unsent; late TLAST arrives with nothing left.
                            if ((remaining > 16'd64 || remaining == 16'd0) &&
                                length_error_count != 16'hFFFF)
                                length_error_count <= length_error_count + 16'd1;
                            state <= S_HDR;
                        end
                    end
                end
                S_SKIP: begin
                    if (in_hs && AXIS_IN_TLAST)
                        state <= S_HDR;
                end
                S_STOP: begin
                    state <= S_STOP;
                end
                default: state <= S_HDR;
            endcase
        end
    end

endmodule
